// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters, bursts of up to MAX_BURST words.
// Optional per-requester accepted-beat counters on stat_cnt when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [ID_W-1:0]               gnt_id,
    output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         stat_cnt
`endif
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  gnt_nxt;
    logic [ID_W-1:0]  rr_last, rr_nxt;
    logic [CNT_W-1:0] burst_cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign data_slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First set request after the previous owner, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] cand;
        logic            found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(last) + i) % NUM_REQ);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_id    <= '0;
            rr_last   <= ID_W'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            gnt_id    <= gnt_nxt;
            rr_last   <= rr_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_id;
        rr_nxt    = rr_last;
        cnt_nxt   = burst_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt   = rr_pick(req, rr_last);
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // A full FIFO freezes everything, including a dropped req.
                if (!fifo_full) begin
                    if (req[gnt_id]) begin
                        if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                            cnt_nxt   = '0;
                            rr_nxt    = gnt_id;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = burst_cnt + CNT_W'(1);
                        end
                    end else begin
                        rr_nxt    = gnt_id;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack          = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        busy         = 1'b0;
        if (state == GRANT) begin
            busy         = 1'b1;
            ack[gnt_id]  = !fifo_full;
            fifo_wr_en   = req[gnt_id] && !fifo_full;
            fifo_wr_data = data_slice[gnt_id];
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stat_q [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stat_q[i] <= '0;
            end else if (fifo_wr_en && gnt_id == ID_W'(i) && stat_q[i] != 16'hFFFF) begin
                stat_q[i] <= stat_q[i] + 16'd1;
            end
        end
        assign stat_cnt[i*16 +: 16] = stat_q[i];
    end
`endif

endmodule
